// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: one partial product per clock, valid/ready on both sides.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands and product.
module seq_mult #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] s,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     s_q, s_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [WIDTH-1:0]  a_load, b_load;
  logic [PW-1:0]     addend, acc_step, result;
  logic              last_step;

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_q, sign_d;

  // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
  assign a_load = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_load = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign result = sign_q ? (~acc_step + PW'(1)) : acc_step;
`else
  assign a_load = a;
  assign b_load = b;
  assign result = acc_step;
`endif

  assign addend    = PW'(mcand_q) << cnt_q;
  assign acc_step  = mplier_q[0] ? (acc_q + addend) : acc_q;
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
`ifdef SEQ_MULT_SIGNED_EN
    sign_d   = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = a_load;
          mplier_d = b_load;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef SEQ_MULT_SIGNED_EN
          sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_step) begin
          s_d     = result;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q   <= sign_d;
`endif
    end
  end

  // Handshake flags come from registered state only; rst merely gates in_ready.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult at WIDTH=4 and WIDTH=8.
// Expected products switch with SEQ_MULT_SIGNED_EN.
module tb_seq_mult;

  logic        clk = 1'b0;
  logic        rst;

  logic        iv4, ir4, ov4, or4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  s4;

  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] s8;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SEQ_MULT_SIGNED_EN
  localparam logic [7:0]  E_15_15 = 8'h01;
  localparam logic [7:0]  E_13_11 = 8'h0F;
  localparam logic [7:0]  E_8_8   = 8'h40;
  localparam logic [7:0]  E_15_7  = 8'hF9;
  localparam logic [7:0]  E_8_7   = 8'hC8;
  localparam logic [15:0] E_FF_FF = 16'h0001;
  localparam logic [15:0] E_80_02 = 16'hFF00;
`else
  localparam logic [7:0]  E_15_15 = 8'hE1;
  localparam logic [7:0]  E_13_11 = 8'h8F;
  localparam logic [7:0]  E_8_8   = 8'h40;
  localparam logic [7:0]  E_15_7  = 8'h69;
  localparam logic [7:0]  E_8_7   = 8'h38;
  localparam logic [15:0] E_FF_FF = 16'hFE01;
  localparam logic [15:0] E_80_02 = 16'h0100;
`endif

  seq_mult #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (iv4),
    .in_ready (ir4),
    .a        (a4),
    .b        (b4),
    .out_valid(ov4),
    .out_ready(or4),
    .s        (s4),
    .busy     (busy4)
  );

  seq_mult #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (iv8),
    .in_ready (ir8),
    .a        (a8),
    .b        (b8),
    .out_valid(ov8),
    .out_ready(or8),
    .s        (s8),
    .busy     (busy8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one WIDTH=4 operation and wait for out_valid, leaving the block in DONE.
  task automatic mul4(input logic [3:0] aa, input logic [3:0] bb,
                      input logic [7:0] exp, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(ir4), 32'd1);
    a4  = aa;
    b4  = bb;
    iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    lat = 1;
    while (ov4 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    chk({tag, "_s"}, 32'(s4), 32'(exp));
    chk({tag, "_busy"}, 32'(busy4), 32'd1);
    chk({tag, "_in_ready_done"}, 32'(ir4), 32'd0);
  endtask

  task automatic handoff4(input logic [7:0] exp, input string tag);
    or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
    chk({tag, "_ov_after"}, 32'(ov4), 32'd0);
    chk({tag, "_rdy_after"}, 32'(ir4), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy4), 32'd0);
    chk({tag, "_s_held"}, 32'(s4), 32'(exp));
  endtask

  task automatic mul8(input logic [7:0] aa, input logic [7:0] bb,
                      input logic [15:0] exp, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(ir8), 32'd1);
    a8  = aa;
    b8  = bb;
    iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    lat = 1;
    while (ov8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd9);
    chk({tag, "_s"}, 32'(s8), 32'(exp));
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk({tag, "_ov_after"}, 32'(ov8), 32'd0);
    chk({tag, "_s_held"}, 32'(s8), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(ir4), 32'd0);
    chk("rst_out_valid", 32'(ov4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_s", 32'(s4), 32'd0);
    chk("rst_s8", 32'(s8), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(ir4), 32'd1);

    mul4(4'd15, 4'd15, E_15_15, "m15x15");
    handoff4(E_15_15, "m15x15");

    // Back-to-back at minimum spacing
    mul4(4'd13, 4'd11, E_13_11, "m13x11");
    handoff4(E_13_11, "m13x11");
    mul4(4'd0, 4'd9, 8'h00, "m0x9");
    handoff4(8'h00, "m0x9");

    // Backpressure: DONE held, input noise ignored
    mul4(4'd8, 4'd8, E_8_8, "m8x8");
    for (int i = 0; i < 10; i++) begin
      iv4 = 1'b1;
      a4  = 4'($urandom);
      b4  = 4'($urandom);
      @(negedge clk);
      chk("bp_s", 32'(s4), 32'(E_8_8));
      chk("bp_out_valid", 32'(ov4), 32'd1);
      chk("bp_in_ready", 32'(ir4), 32'd0);
    end
    iv4 = 1'b0;
    handoff4(E_8_8, "m8x8");

    mul4(4'd15, 4'd7, E_15_7, "m15x7");
    handoff4(E_15_7, "m15x7");
    mul4(4'd0, 4'd13, 8'h00, "m0x13");
    handoff4(8'h00, "m0x13");
    mul4(4'd8, 4'd7, E_8_7, "m8x7");
    handoff4(E_8_7, "m8x7");

    // Reset on the second BUSY cycle of 7x6
    @(negedge clk);
    a4  = 4'd7;
    b4  = 4'd6;
    iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    chk("midrst_busy_before", 32'(busy4), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(ov4), 32'd0);
    chk("midrst_s", 32'(s4), 32'd0);
    chk("midrst_busy", 32'(busy4), 32'd0);
    chk("midrst_in_ready", 32'(ir4), 32'd0);
    rst = 1'b0;
    mul4(4'd3, 4'd5, 8'd15, "m3x5");
    handoff4(8'd15, "m3x5");

    mul8(8'd255, 8'd255, E_FF_FF, "w8_255x255");
    mul8(8'd128, 8'd2, E_80_02, "w8_128x2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
